// File: rtl/rr_arb_pkg.sv
// Shared types and the rotating-priority pick function for rr_stream_arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE, LOCKED} rr_arb_state_e;

  // Upper bound on requester count that rr_pick can scan.
  localparam int unsigned RR_MAX_N = 64;

  // Returns the first set bit of valid[n-1:0], scanning prio+1, prio+2, ...
  // modulo n. Returns 0 when nothing is set.
  function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] valid,
                                          input int unsigned prio,
                                          input int unsigned n);
    int unsigned idx;
    rr_pick = 0;
    // Scan from the far end so the nearest hit in rotation order wins last.
    for (int unsigned k = RR_MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        idx = (prio + k) % n;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/fifo.sv
// Small circular-buffer FIFO with valid/ready on both sides; optional fall-through when empty.
module fifo #(
  parameter type         TYPE         = logic,
  parameter int unsigned CAPACITY     = 2,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic wr_valid,
  output logic wr_ready,
  input  TYPE  wr_data,
  output logic rd_valid,
  input  logic rd_ready,
  output TYPE  rd_data
);

  localparam int unsigned AW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(CAPACITY);
  localparam logic [AW-1:0] LAST_PTR = AW'(CAPACITY - 1);

  TYPE           mem [CAPACITY];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;

  // wr_ready depends only on occupancy, so no combinational path from rd_ready.
  always_comb begin
    empty    = (count == '0);
    bypass   = FALL_THROUGH && empty;
    wr_ready = (count != FULL_CNT);
    rd_valid = bypass ? wr_valid : !empty;
    rd_data  = bypass ? wr_data : mem[rd_ptr];
    push     = wr_valid && wr_ready && !(bypass && rd_ready);
    pop      = rd_valid && rd_ready && !bypass;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-atomic round-robin merge of N valid/ready streams onto one channel.
// Define RR_STREAM_ARBITER_OUT_REG_EN to register the outputs through a 2-entry slice.
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter type         TYPE = logic,
  parameter int unsigned N    = 4,
  parameter int unsigned IDW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  TYPE            i_data [N],
  input  logic [N-1:0]   i_last,
  output logic           o_valid,
  input  logic           o_ready,
  output TYPE            o_data,
  output logic           o_last,
  output logic [IDW-1:0] o_id
);

  if (N < 2) begin : g_bad_n
    $fatal(1, "rr_stream_arbiter: N must be at least 2");
  end

  localparam logic [IDW-1:0] PRIO_RST = IDW'(N - 1);

  rr_arb_state_e  state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] prio, prio_nxt;
  logic [IDW-1:0] grant;
  logic           arb_valid;
  logic           arb_ready;
  logic           arb_last;
  TYPE            arb_data;

  always_comb begin
    if (state == LOCKED) grant = owner;
    else                 grant = IDW'(rr_pick(RR_MAX_N'(i_valid), int'(prio), N));
    arb_valid        = i_valid[grant];
    arb_data         = i_data[grant];
    arb_last         = i_last[grant];
    i_ready          = '0;
    i_ready[grant]   = arb_ready;
  end

  // Valid/ready: a beat moves when valid && ready on the same edge; a source
  // holds valid and its beat stable until then, and a grant is never revoked.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          if (!arb_ready || !arb_last) begin
            state_nxt = LOCKED;
            owner_nxt = grant;
          end else begin
            prio_nxt = grant;
          end
        end
      end
      LOCKED: begin
        if (arb_valid && arb_ready && arb_last) begin
          state_nxt = IDLE;
          prio_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= '0;
      prio  <= PRIO_RST;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
    end
  end

`ifdef RR_STREAM_ARBITER_OUT_REG_EN
  typedef struct packed {
    TYPE            data;
    logic           last;
    logic [IDW-1:0] id;
  } beat_t;

  beat_t wr_beat;
  beat_t rd_beat;

  assign wr_beat = '{data: arb_data, last: arb_last, id: grant};

  fifo #(
    .TYPE        (beat_t),
    .CAPACITY    (2),
    .FALL_THROUGH(1'b0)
  ) u_out_slice (
    .clk     (clk),
    .rstn    (rstn),
    .wr_valid(arb_valid),
    .wr_ready(arb_ready),
    .wr_data (wr_beat),
    .rd_valid(o_valid),
    .rd_ready(o_ready),
    .rd_data (rd_beat)
  );

  assign o_data = rd_beat.data;
  assign o_last = rd_beat.last;
  assign o_id   = rd_beat.id;
`else
  assign arb_ready = o_ready;
  assign o_valid   = arb_valid;
  assign o_data    = arb_data;
  assign o_last    = arb_last;
  assign o_id      = grant;
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (N=4, 8-bit payload); inputs change on negedge, outputs checked 1ns later.
module tb_rr_stream_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] i_valid;
  logic [3:0] i_ready;
  logic [7:0] i_data [4];
  logic [3:0] i_last;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_last;
  logic [1:0] o_id;

  int n_cmp;
  int n_err;

  rr_stream_arbiter #(
    .TYPE(logic [7:0]),
    .N   (4)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_data (i_data),
    .i_last (i_last),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_last (o_last),
    .o_id   (o_id)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_data(input int base);
    for (int r = 0; r < 4; r++) i_data[r] = 8'(base + 16 * r);
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    i_valid = '0;
    i_last  = '0;
    o_ready = 1'b0;
    set_data(1);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({o_valid, i_ready} !== 5'b0_0000) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b ready=%b, expected valid=0 ready=0000", o_valid, i_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_rr_all();
    logic [1:0] exp_id [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      i_valid = 4'b1111;
      i_last  = 4'b1111;
      o_ready = 1'b1;
      set_data(1);
      #1;
      n_cmp++;
      if ({o_valid, o_id, o_data, o_last, i_ready} !==
          {1'b1, exp_id[k], 8'(1 + 16 * exp_id[k]), 1'b1, 4'(1 << exp_id[k])}) begin
        n_err++;
        $display("FAIL rr_all[%0d]: got v=%b id=%0d d=%h l=%b rdy=%b, expected v=1 id=%0d d=%h l=1 rdy=%b",
                 k, o_valid, o_id, o_data, o_last, i_ready, exp_id[k], 8'(1 + 16 * exp_id[k]),
                 4'(1 << exp_id[k]));
      end
      @(negedge clk);
    end
    i_valid = '0;
    @(negedge clk);
  endtask

  // prio is 0 on entry; a lone req1 beat moves it to 1 so req2 wins next.
  task automatic test_packet();
    i_valid = 4'b0010;
    i_last  = 4'b1111;
    o_ready = 1'b1;
    set_data(8'h40);
    #1;
    n_cmp++;
    if (o_id !== 2'd1) begin
      n_err++;
      $display("FAIL pkt_setup: got id=%0d, expected 1", o_id);
    end
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      i_valid = 4'b0110;
      i_last  = (b == 2) ? 4'b1111 : 4'b1011;
      set_data(8'h40 + b);
      #1;
      n_cmp++;
      if ({o_id, o_data, o_last, i_ready} !== {2'd2, 8'(8'h60 + b), (b == 2), 4'b0100}) begin
        n_err++;
        $display("FAIL pkt_beat[%0d]: got id=%0d d=%h l=%b rdy=%b, expected id=2 d=%h l=%b rdy=0100",
                 b, o_id, o_data, o_last, i_ready, 8'(8'h60 + b), (b == 2));
      end
      @(negedge clk);
    end
    i_valid = 4'b0010;
    i_last  = 4'b1111;
    #1;
    n_cmp++;
    if ({o_id, i_ready} !== {2'd1, 4'b0010}) begin
      n_err++;
      $display("FAIL pkt_next: got id=%0d rdy=%b, expected id=1 rdy=0010", o_id, i_ready);
    end
    @(negedge clk);
    i_valid = '0;
    @(negedge clk);
  endtask

  // prio is 1 on entry: req3 wins alone, then req2 (higher rotation) shows up.
  task automatic test_stall();
    o_ready = 1'b0;
    i_last  = 4'b1111;
    set_data(8'h0C);
    for (int c = 0; c < 6; c++) begin
      i_valid = (c == 0) ? 4'b1000 : 4'b1100;
      o_ready = (c == 5);
      #1;
      n_cmp++;
      if ({o_valid, o_id, o_data, i_ready} !== {1'b1, 2'd3, 8'h3C, (c == 5) ? 4'b1000 : 4'b0000}) begin
        n_err++;
        $display("FAIL stall[%0d]: got v=%b id=%0d d=%h rdy=%b, expected v=1 id=3 d=3c rdy=%b",
                 c, o_valid, o_id, o_data, i_ready, (c == 5) ? 4'b1000 : 4'b0000);
      end
      @(negedge clk);
    end
    i_valid = 4'b0100;
    #1;
    n_cmp++;
    if ({o_id, o_data, i_ready} !== {2'd2, 8'h2C, 4'b0100}) begin
      n_err++;
      $display("FAIL stall_after: got id=%0d d=%h rdy=%b, expected id=2 d=2c rdy=0100", o_id, o_data, i_ready);
    end
    @(negedge clk);
    i_valid = '0;
    @(negedge clk);
  endtask

  // prio is 2 on entry; a lone req3 beat sets prio=3.
  task automatic test_wrap();
    o_ready = 1'b1;
    i_last  = 4'b1111;
    i_valid = 4'b1000;
    @(negedge clk);
    i_valid = 4'b1001;
    #1;
    n_cmp++;
    if (o_id !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_first: got id=%0d, expected 0", o_id);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (o_id !== 2'd3) begin
      n_err++;
      $display("FAIL wrap_second: got id=%0d, expected 3", o_id);
    end
    @(negedge clk);
    i_valid = '0;
    @(negedge clk);
  endtask

  // prio is 3 on entry; lock on req1, reset, then req0 must win.
  task automatic test_reset_mid();
    o_ready = 1'b1;
    i_valid = 4'b0010;
    i_last  = 4'b0000;
    #1;
    n_cmp++;
    if (o_id !== 2'd1) begin
      n_err++;
      $display("FAIL rmid_start: got id=%0d, expected 1", o_id);
    end
    @(negedge clk);
    i_valid = 4'b0011;
    #1;
    n_cmp++;
    if ({o_id, i_ready} !== {2'd1, 4'b0010}) begin
      n_err++;
      $display("FAIL rmid_locked: got id=%0d rdy=%b, expected id=1 rdy=0010", o_id, i_ready);
    end
    #2;
    i_valid = '0;
    rstn    = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_in_reset: got valid=%b, expected 0", o_valid);
    end
    @(negedge clk);
    rstn    = 1'b1;
    i_valid = 4'b0011;
    i_last  = 4'b1111;
    #1;
    n_cmp++;
    if ({o_id, i_ready} !== {2'd0, 4'b0001}) begin
      n_err++;
      $display("FAIL rmid_after: got id=%0d rdy=%b, expected id=0 rdy=0001", o_id, i_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (o_id !== 2'd1) begin
      n_err++;
      $display("FAIL rmid_next: got id=%0d, expected 1", o_id);
    end
    @(negedge clk);
    i_valid = '0;
    @(negedge clk);
  endtask

  // Registered-output build: one cycle of latency, same grant order.
  task automatic test_out_reg();
    logic [1:0] exp_id [5];
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    i_valid = 4'b1111;
    i_last  = 4'b1111;
    o_ready = 1'b1;
    set_data(1);
    #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL oreg_first: got valid=%b, expected 0", o_valid);
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({o_valid, o_id, o_data} !== {1'b1, exp_id[k], 8'(1 + 16 * exp_id[k])}) begin
        n_err++;
        $display("FAIL oreg[%0d]: got v=%b id=%0d d=%h, expected v=1 id=%0d d=%h",
                 k, o_valid, o_id, o_data, exp_id[k], 8'(1 + 16 * exp_id[k]));
      end
      @(negedge clk);
    end
    i_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
`ifdef RR_STREAM_ARBITER_OUT_REG_EN
    test_out_reg();
`else
    test_rr_all();
    test_packet();
    test_stall();
    test_wrap();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that merges N valid/ready requester streams onto one shared downstream channel, typically the write side of a shared FIFO. Grants are packet-atomic: once a requester wins, it owns the channel until its `last` beat is accepted. A granted but unaccepted beat is never revoked. Each output beat carries the source index so the consumer can demultiplex responses.

## Interface
Parameters:
- `TYPE`, default `logic`: payload type per beat.
- `N`, default `4`: number of requesters; must be ≥ 2 (checked by `$fatal`).
- `IDW`, default `$clog2(N)`: width of the source index.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  N  per-requester valid.
- `i_ready`  out  N  per-requester ready.
- `i_data`  in  TYPE[N]  per-requester payload.
- `i_last`  in  N  per-requester end-of-packet flag.
- `o_valid`  out  1  downstream valid.
- `o_ready`  in  1  downstream ready.
- `o_data`  out  TYPE  granted payload.
- `o_last`  out  1  granted end-of-packet flag.
- `o_id`  out  IDW  index of the granted requester.

## Operation
- State registers:
  - `state` ∈ {IDLE, LOCKED}, reset IDLE.
  - `owner[IDW]`, reset 0.
  - `prio[IDW]` (last-served index), reset N-1, so requester 0 has first priority.
- IDLE:
  - `grant` = the first requester with `i_valid` set, scanning `prio+1`, `prio+2`, … modulo N (wrap from N-1 to 0).
  - If no `i_valid` is set, `o_valid`=0, all `i_ready`=0, and `o_data`/`o_id` are don't-care.
- LOCKED: `grant` = `owner`, regardless of the other requesters.
- Muxing:
  - `o_valid` = `i_valid[grant]`; `o_data` = `i_data[grant]`; `o_last` = `i_last[grant]`; `o_id` = `grant`.
  - `i_ready[grant]` = `o_ready`; every other `i_ready` = 0.
- Transitions, evaluated at the clock edge (`hs` = `o_valid && o_ready`):
  - IDLE, `o_valid && !o_ready`: go to LOCKED, `owner`←`grant`. This is a stall lock; it keeps the output stable.
  - IDLE, `hs && !o_last`: go to LOCKED, `owner`←`grant`.
  - IDLE, `hs && o_last`: stay IDLE, `prio`←`grant`.
  - LOCKED, `hs && o_last`: go to IDLE, `prio`←`owner`.
  - LOCKED, otherwise: stay LOCKED.
- `prio` updates only on an accepted `last` beat, so fairness is per packet, not per beat.
- Reset mid-packet: the state returns to IDLE and `prio` to N-1. The packet in progress is abandoned; no flush or recovery is attempted.

## Timing
- Without the output register: zero latency. The `o_*` outputs are combinational from `i_*`, `state`, `owner` and `prio`; `i_ready` is combinational from `o_ready`.
- Throughput: 1 beat per cycle. A change of owner after a `last` beat costs no bubble.
- Simultaneous requests: the winner is decided purely by the rotation from `prio`.
- A requester that drops `i_valid` while LOCKED stalls the channel; this is legal, and the lock is held.
- Outputs during reset: `o_valid`=0 only if all `i_valid`=0. Sources must hold `i_valid` low during reset.
- Worst-case wait for a requester: N-1 packets.

## Configuration
- Macro: `RR_STREAM_ARBITER_OUT_REG_EN`.
- Defined:
  - Inserts a 2-entry register slice on {`o_data`, `o_last`, `o_id`}.
  - `o_valid` resets to 0 and outputs are registered, so beats reach the output 1 cycle later.
  - The `o_ready`→`i_ready` combinational path is cut; the arbiter sees the slice's write-ready in place of `o_ready`.
  - Full throughput is retained.
- Undefined: the purely combinational behaviour above.

## Structure
- Package `rr_arb_pkg`:
  - `typedef enum logic {IDLE, LOCKED} rr_arb_state_e`.
  - Function `rr_pick(valid, prio)` returning the rotated first-set index.
- Sub-module, used only under the macro: the codebase `fifo` instance with `TYPE` = struct {`TYPE` data; `logic` last; `logic[IDW-1:0]` id}, `CAPACITY`=2, `FALL_THROUGH`=0.

## Test plan
- Reset, then `i_valid`=4'b1111, all `i_last`=1, `o_ready`=1: `o_id` sequence is 0, 1, 2, 3, 0, one grant per cycle.
- Requester 2 sends a 3-beat packet while requester 1 asserts valid throughout: `o_id` reads 2, 2, 2, then 1; `i_ready[1]`=0 during the packet.
- Grant with `o_ready`=0 for 5 cycles while a higher-rotation requester raises valid: `o_id`/`o_data` stay stable, and the original beat is accepted when `o_ready`=1.
- `prio`=3, only requesters 0 and 3 valid: grant 0 (wrap-around); the next grant is 3.
- Assert `rstn`=0 mid-packet (owner 1), release, then present valid on requesters 1 and 0: grant 0 (prio reset to N-1).
- With `RR_STREAM_ARBITER_OUT_REG_EN`: the same traffic as the first test shows `o_valid`=0 immediately after reset and a 1-cycle latency, and yields an identical `o_id` sequence.
